// File: rtl/squash_rally_ctrl.sv
// rtl/squash_rally_ctrl.sv - match sequencer for the 1-D squash game on a 16-LED bar
//
// Owns the ball position, whose-turn arbitration, rally/point sequencing,
// serve rotation and scores. The wall is at light[15]; both players stand at
// light[0] and their hits must alternate.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous assert, active-low
//   rightplayer  in   1   right button level, debounced
//   leftplayer   in   1   left button level, debounced
//   light        out  16  one-hot ball position or point/game-over pattern
//   rightpscore  out  2   right player score
//   leftpscore   out  2   left player score
//   turn         out  1   1 = right must hit next, 0 = left
//   game_over    out  1   high once a score reaches WIN_SCORE
module squash_rally_ctrl #(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned HIT_WIN     = 2,
  parameter int unsigned FLASH_TICKS = 8,
  parameter int unsigned WIN_SCORE   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rightplayer,
  input  logic        leftplayer,
  output logic [15:0] light,
  output logic [1:0]  rightpscore,
  output logic [1:0]  leftpscore,
  output logic        turn,
  output logic        game_over
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
  localparam logic [4:0]    HIT_LIM    = 5'(HIT_WIN);
  localparam logic [1:0]    SCORE_MAX  = 2'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OUT,
    S_IN,
    S_POINT,
    S_OVER
  } state_t;

  // Player identity everywhere below: 1 = right, 0 = left.
  state_t        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [1:0]    rscore_q, rscore_d;
  logic [1:0]    lscore_q, lscore_d;
  logic          server_q, server_d;
  logic          turn_q, turn_d;
  logic          winner_q, winner_d;
  logic          pend_q, pend_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          rprev_q, lprev_q;
  logic [15:0]   light_q, light_d;
  logic          over_q, over_d;

  logic          tick;
  logic          r_press, l_press;
  logic          turn_press, other_press, server_press;
  logic [1:0]    win_score;

  assign tick    = (presc_q == PRESC_LAST);
  assign r_press = rightplayer & ~rprev_q;
  assign l_press = leftplayer & ~lprev_q;

  assign turn_press   = turn_q   ? r_press : l_press;
  assign other_press  = turn_q   ? l_press : r_press;
  assign server_press = server_q ? r_press : l_press;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    rscore_d  = rscore_q;
    lscore_d  = lscore_q;
    server_d  = server_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    pend_d    = 1'b0;
    flash_d   = flash_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    win_score = 2'd0;

    // The point is credited on the first POINT cycle (pend_q), one clock
    // after entry; saturating so a score never passes WIN_SCORE.
    if (pend_q) begin
      if (winner_q) begin
        if (rscore_q < SCORE_MAX) rscore_d = rscore_q + 2'd1;
      end else begin
        if (lscore_q < SCORE_MAX) lscore_d = lscore_q + 2'd1;
      end
    end
    win_score = winner_q ? rscore_d : lscore_d;

    case (state_q)
      S_IDLE: begin
        if (server_press) begin
          state_d = S_OUT;
          turn_d  = ~server_q;
        end
      end
      S_OUT: begin
        if (tick) begin
          if (pos_q == 4'd15) state_d = S_IN;
          else                pos_d   = pos_q + 4'd1;
        end
      end
      S_IN: begin
        // Priority: valid hit, then hindrance, then the ball step / miss.
        if (turn_press && ({1'b0, pos_q} < HIT_LIM)) begin
          state_d = S_OUT;
          turn_d  = ~turn_q;
        end else if (other_press) begin
          state_d  = S_POINT;
          winner_d = turn_q;
          pend_d   = 1'b1;
          flash_d  = '0;
        end else if (tick) begin
          if (pos_q == 4'd0) begin
            state_d  = S_POINT;
            winner_d = ~turn_q;
            pend_d   = 1'b1;
            flash_d  = '0;
          end else begin
            pos_d = pos_q - 4'd1;
          end
        end
      end
      S_POINT: begin
        if (tick) begin
          if (flash_q == FLASH_LAST) begin
            if (win_score == SCORE_MAX) begin
              state_d = S_OVER;
            end else begin
              state_d  = S_IDLE;
              pos_d    = 4'd0;
              server_d = winner_q;
              turn_d   = winner_q;
            end
          end else begin
            flash_d = flash_q + FW'(1);
          end
        end
      end
      S_OVER: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state so they move on the causing edge.
    case (state_d)
      S_POINT: light_d = winner_d ? 16'hFF00 : 16'h00FF;
      S_OVER:  light_d = 16'hFFFF;
      default: light_d = 16'h0001 << pos_d;
    endcase
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pos_q    <= 4'd0;
      rscore_q <= 2'd0;
      lscore_q <= 2'd0;
      server_q <= 1'b1;
      turn_q   <= 1'b1;
      winner_q <= 1'b1;
      pend_q   <= 1'b0;
      flash_q  <= '0;
      presc_q  <= '0;
      // History starts high so a button held through reset is not a press.
      rprev_q  <= 1'b1;
      lprev_q  <= 1'b1;
      light_q  <= 16'h0001;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      rscore_q <= rscore_d;
      lscore_q <= lscore_d;
      server_q <= server_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
      presc_q  <= presc_d;
      rprev_q  <= rightplayer;
      lprev_q  <= leftplayer;
      light_q  <= light_d;
      over_q   <= over_d;
    end
  end

  assign light       = light_q;
  assign rightpscore = rscore_q;
  assign leftpscore  = lscore_q;
  assign turn        = turn_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_squash_rally_ctrl.sv
// tb/tb_squash_rally_ctrl.sv - self-checking bench for squash_rally_ctrl
module tb_squash_rally_ctrl;

  localparam int TD = 4;
  localparam int HW = 2;
  localparam int FT = 2;
  localparam int WS = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rightplayer = 1'b1;
  logic        leftplayer = 1'b1;
  logic [15:0] light;
  logic [1:0]  rightpscore;
  logic [1:0]  leftpscore;
  logic        turn;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  squash_rally_ctrl #(
    .TICK_DIV(TD), .HIT_WIN(HW), .FLASH_TICKS(FT), .WIN_SCORE(WS)
  ) dut (
    .clock(clock), .reset(reset), .rightplayer(rightplayer), .leftplayer(leftplayer),
    .light(light), .rightpscore(rightpscore), .leftpscore(leftpscore),
    .turn(turn), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Reference model: players indexed 1 = right, 0 = left. The ball is a
  // position plus a direction of travel (+1 toward the wall, -1 back).
  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_FLASH = 2;
  localparam int M_DONE  = 3;

  int m_mode, m_pos, m_dir, m_server, m_turn, m_winner, m_credited, m_shown, m_phase;
  int m_score[2];
  bit m_prev[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SERVE; m_pos = 0; m_dir = 1; m_server = 1; m_turn = 1;
    m_winner = 1; m_credited = 1; m_shown = 0; m_phase = 0;
    m_score[0] = 0; m_score[1] = 0;
    m_prev[0] = 1'b1; m_prev[1] = 1'b1;
  endtask

  task automatic award(input int p);
    m_mode = M_FLASH; m_winner = p; m_credited = 0; m_shown = 0;
  endtask

  task automatic model_step(input bit r, input bit l);
    bit hit[2];
    bit tk;
    hit[1] = r && !m_prev[1];
    hit[0] = l && !m_prev[0];
    m_prev[1] = r;
    m_prev[0] = l;
    tk = (m_phase == TD - 1);
    m_phase = (m_phase + 1) % TD;
    case (m_mode)
      M_SERVE: if (hit[m_server]) begin
        m_mode = M_PLAY; m_dir = 1; m_turn = 1 - m_server;
      end
      M_PLAY: begin
        if (m_dir > 0) begin
          if (tk) begin
            if (m_pos == 15) m_dir = -1;
            else m_pos++;
          end
        end else if (hit[m_turn] && m_pos < HW) begin
          m_dir = 1; m_turn = 1 - m_turn;
        end else if (hit[1 - m_turn]) begin
          award(m_turn);
        end else if (tk) begin
          if (m_pos == 0) award(1 - m_turn);
          else m_pos--;
        end
      end
      M_FLASH: begin
        if (m_credited == 0) begin
          if (m_score[m_winner] < WS) m_score[m_winner]++;
          m_credited = 1;
        end
        if (tk) begin
          m_shown++;
          if (m_shown == FT) begin
            if (m_score[m_winner] == WS) m_mode = M_DONE;
            else begin
              m_mode = M_SERVE; m_pos = 0; m_server = m_winner; m_turn = m_winner;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] exp_light();
    case (m_mode)
      M_FLASH: return (m_winner == 1) ? 16'hFF00 : 16'h00FF;
      M_DONE:  return 16'hFFFF;
      default: return 16'(1) << m_pos;
    endcase
  endfunction

  task automatic compare_all();
    check_eq("light", light, exp_light());
    check_eq("rscore", rightpscore, m_score[1]);
    check_eq("lscore", leftpscore, m_score[0]);
    check_eq("turn", turn, m_turn);
    check_eq("game_over", game_over, m_mode == M_DONE);
  endtask

  task automatic cyc(input bit r, input bit l);
    @(negedge clock);
    rightplayer = r;
    leftplayer  = l;
    @(posedge clock);
    model_step(r, l);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_light"}, light, 16'h0001);
    check_eq({tag, "_rscore"}, rightpscore, 0);
    check_eq({tag, "_lscore"}, leftpscore, 0);
    check_eq({tag, "_turn"}, turn, 1);
    check_eq({tag, "_gover"}, game_over, 0);
  endtask

  // Asserts reset away from the clock edge and checks it takes effect at once.
  task automatic do_reset(input bit r, input bit l);
    @(posedge clock);
    #2;
    reset = 1'b0;
    rightplayer = r;
    leftplayer = l;
    #1;
    check_reset_values("async_rst");
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_light(input logic [15:0] target, input int budget);
    int n = 0;
    while (light !== target && n < budget) begin
      cyc(0, 0);
      n++;
    end
    check_eq("wait_light", n < budget, 1);
  endtask

  task automatic wait_return(input int p);
    int n = 0;
    while (!(m_mode == M_PLAY && m_dir < 0 && m_pos == p && light === (16'(1) << p)) && n < 300) begin
      cyc(0, 0);
      n++;
    end
    check_eq("wait_return", n < 300, 1);
  endtask

  task automatic wait_not_flash();
    int n = 0;
    while ((light === 16'hFF00 || light === 16'h00FF) && n < 50) begin
      cyc(0, 0);
      n++;
    end
    check_eq("wait_flash_end", n < 50, 1);
  endtask

  task automatic serve();
    cyc(0, 0);
    cyc(m_server == 1, m_server == 0);
    cyc(0, 0);
  endtask

  task automatic give_right_point();
    if (m_server == 0) begin
      serve();
      wait_return(10);
      cyc(0, 1);
    end else begin
      serve();
      wait_light(16'hFF00, 400);
    end
    wait_not_flash();
  endtask

  task automatic bot_cycle();
    bit r, l;
    r = ($urandom_range(0, 63) == 0);
    l = ($urandom_range(0, 63) == 0);
    if (m_mode == M_SERVE && $urandom_range(0, 7) == 0) begin
      if (m_server == 1) r = 1'b1; else l = 1'b1;
    end
    if (m_mode == M_PLAY && m_dir < 0 && m_pos < HW && $urandom_range(0, 2) != 0) begin
      if (m_turn == 1) r = 1'b1; else l = 1'b1;
    end
    cyc(r, l);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("rst");
    model_reset();
    @(posedge clock);
    #2 reset = 1'b1;

    // Buttons held through reset release are not presses.
    cyc(1, 1);
    cyc(1, 1);
    check_eq("held_light", light, 16'h0001);
    cyc(0, 0);
    cyc(1, 0);
    check_eq("serve_turn", turn, 0);

    // Unanswered serve: full trip out and back, then a miss for left.
    cyc(0, 0);
    wait_light(16'hFF00, 400);
    cyc(0, 0);
    check_eq("miss_rscore", rightpscore, 1);
    wait_light(16'h0001, 100);
    check_eq("after_miss_turn", turn, 1);

    // Valid return, then a turn-holder press too far away is ignored.
    serve();
    wait_return(1);
    cyc(0, 1);
    check_eq("hit_turn", turn, 1);
    check_eq("hit_lscore", leftpscore, 0);
    cyc(0, 0);
    wait_return(3);
    cyc(1, 0);
    check_eq("far_press_turn", turn, 1);
    cyc(0, 0);
    wait_return(1);
    cyc(1, 0);
    check_eq("right_hit_turn", turn, 0);
    cyc(0, 0);

    // Hindrance by the non-turn player.
    wait_return(8);
    cyc(1, 0);
    check_eq("hind_light", light, 16'h00FF);
    cyc(0, 0);
    check_eq("hind_lscore", leftpscore, 1);
    wait_light(16'h0001, 100);

    // Same-clock presses at position 0: the turn-holder's valid hit wins.
    serve();
    wait_return(1);
    cyc(1, 0);
    cyc(0, 0);
    wait_return(0);
    cyc(1, 1);
    check_eq("both_turn", turn, 1);
    check_eq("both_rscore", rightpscore, 1);
    check_eq("both_lscore", leftpscore, 1);
    cyc(0, 0);
    wait_light(16'h00FF, 400);
    wait_not_flash();

    // Right to three points, then the game is frozen.
    for (int k = 0; k < 8 && m_mode != M_DONE; k++) give_right_point();
    check_eq("go_light", light, 16'hFFFF);
    check_eq("go_flag", game_over, 1);
    check_eq("go_rscore", rightpscore, 3);
    for (int k = 0; k < 40; k++) cyc($urandom_range(0, 1), $urandom_range(0, 1));
    check_eq("go_frozen", light, 16'hFFFF);

    // Reset mid-rally.
    do_reset(0, 0);
    serve();
    repeat (30) cyc(0, 0);
    do_reset(0, 1);

    // Randomized games, each ended by an asynchronous reset.
    for (int g = 0; g < 4; g++) begin
      int lim;
      lim = $urandom_range(300, 4000);
      for (int n = 0; n < lim && m_mode != M_DONE; n++) bot_cycle();
      repeat (10) bot_cycle();
      do_reset($urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
